// File: rtl/bram_dbg_pkg.sv
// rtl/bram_dbg_pkg.sv - shared types and constants for the BRAM debug sequencer
package bram_dbg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_D,
    S_LOAD_I,
    S_CORE_RST,
    S_RUN,
    S_DUMP_D,
    S_DUMP_I,
    S_DONE
  } seqState_t;

  typedef enum logic [1:0] {
    P_ISSUE,
    P_CAPT,
    P_PRESENT
  } dumpPhase_t;

  localparam logic [3:0]  WE_ALL    = 4'hF;
  localparam logic [31:0] ADDR_STEP = 32'd4;

  // One counter is shared by load, reset-pulse, run and dump phases.
  function automatic int cntWidth(input int words, input int cycles, input int pulse);
    int m;
    m = (words > cycles) ? words : cycles;
    if (pulse > m) m = pulse;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/bram_dbg_port.sv
// rtl/bram_dbg_port.sv - per-RAM debug port driver with read-capture register
module bram_dbg_port
  import bram_dbg_pkg::*;
(
  input  logic        CPU_CLK,
  input  logic        CPU_RST_N,
  input  logic        wrEn,
  input  logic [31:0] wrAddr,
  input  logic [31:0] wrData,
  input  logic        rdEn,
  input  logic [31:0] rdAddr,
  input  logic        capEn,
  input  logic [31:0] rd2,
  output logic [31:0] a2,
  output logic [31:0] wd2,
  output logic [3:0]  we2,
  output logic [31:0] capData
);

  logic [31:0] a2Reg;

  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST_N) begin
      a2Reg   <= '0;
      wd2     <= '0;
      we2     <= '0;
      capData <= '0;
    end else begin
      we2 <= wrEn ? WE_ALL : 4'h0;
      if (wrEn) begin
        a2Reg <= wrAddr;
        wd2   <= wrData;
      end
      if (capEn) capData <= rd2;
    end
  end

  // Read address bypasses the register so rd2 lands in the following cycle.
  assign a2 = rdEn ? rdAddr : a2Reg;

endmodule

// File: rtl/bram_debug_sequencer.sv
// rtl/bram_debug_sequencer.sv - load/run/dump sequencer driving the RV32 debug BRAM ports
module bram_debug_sequencer
  import bram_dbg_pkg::*;
#(
  parameter int BRAM_WORDS = 4096,
  parameter int RUN_CYCLES = 200000,
  parameter int RST_PULSE  = 5
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST_N,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        core_rst,
  output logic [31:0] dbg_d_a2,
  output logic [31:0] dbg_d_wd2,
  output logic [3:0]  dbg_d_we2,
  input  logic [31:0] dbg_d_rd2,
  output logic [31:0] dbg_i_a2,
  output logic [31:0] dbg_i_wd2,
  output logic [3:0]  dbg_i_we2,
  input  logic [31:0] dbg_i_rd2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_addr,
  output logic        out_sel,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int CW = cntWidth(BRAM_WORDS, RUN_CYCLES, RST_PULSE);
  localparam logic [CW-1:0] WORDS_C    = CW'(BRAM_WORDS);
  localparam logic [CW-1:0] WORDS_LAST = CW'(BRAM_WORDS - 1);
  localparam logic [CW-1:0] RUN_LAST   = CW'(RUN_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(RST_PULSE - 1);

  seqState_t   state, stateNext;
  dumpPhase_t  phase, phaseNext;
  logic [CW-1:0] cnt, cntNext;
  logic [31:0] addr, addrNext, outAddrReg, outAddrNext;
  logic        outSelReg, outSelNext;
  logic        loading, loadAcc, dumping;
  logic [31:0] dCap, iCap;

  assign loading   = (state == S_LOAD_D) || (state == S_LOAD_I);
  assign dumping   = (state == S_DUMP_D) || (state == S_DUMP_I);
  assign in_ready  = loading && (cnt < WORDS_C);
  assign loadAcc   = in_valid && in_ready;
  assign out_valid = dumping && (phase == P_PRESENT);
  assign out_last  = out_valid && (state == S_DUMP_I) && (cnt == WORDS_LAST);
  assign core_rst  = (state != S_RUN);
  assign busy      = (state != S_IDLE) && (state != S_DONE);
  assign done      = (state == S_DONE);
  assign out_addr  = outAddrReg;
  assign out_sel   = outSelReg;
  assign out_data  = outSelReg ? iCap : dCap;

  always_ff @(posedge CPU_CLK) begin
    if (!CPU_RST_N) begin
      state      <= S_IDLE;
      phase      <= P_ISSUE;
      cnt        <= '0;
      addr       <= '0;
      outAddrReg <= '0;
      outSelReg  <= 1'b0;
    end else begin
      state      <= stateNext;
      phase      <= phaseNext;
      cnt        <= cntNext;
      addr       <= addrNext;
      outAddrReg <= outAddrNext;
      outSelReg  <= outSelNext;
    end
  end

  always_comb begin
    stateNext   = state;
    phaseNext   = phase;
    cntNext     = cnt;
    addrNext    = addr;
    outAddrNext = outAddrReg;
    outSelNext  = outSelReg;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          stateNext = S_LOAD_D;
          cntNext   = '0;
          addrNext  = '0;
          phaseNext = P_ISSUE;
        end
      end
      S_LOAD_D, S_LOAD_I: begin
        if (loadAcc) begin
          cntNext  = cnt + 1'b1;
          addrNext = addr + ADDR_STEP;
        end
        // A full image idles in_ready for one cycle before the phase advances.
        if ((loadAcc && in_last) || (cnt == WORDS_C)) begin
          stateNext = (state == S_LOAD_D) ? S_LOAD_I : S_CORE_RST;
          cntNext   = '0;
          addrNext  = '0;
        end
      end
      S_CORE_RST: begin
        if (cnt == PULSE_LAST) begin
          stateNext = S_RUN;
          cntNext   = '0;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (cnt == RUN_LAST) begin
          stateNext = S_DUMP_D;
          cntNext   = '0;
          addrNext  = '0;
          phaseNext = P_ISSUE;
        end else begin
          cntNext = cnt + 1'b1;
        end
      end
      S_DUMP_D, S_DUMP_I: begin
        case (phase)
          P_ISSUE: phaseNext = P_CAPT;
          P_CAPT: begin
            outAddrNext = addr;
            outSelNext  = (state == S_DUMP_I);
            phaseNext   = P_PRESENT;
          end
          P_PRESENT: begin
            if (out_ready) begin
              phaseNext = P_ISSUE;
              if (cnt == WORDS_LAST) begin
                stateNext = (state == S_DUMP_D) ? S_DUMP_I : S_DONE;
                cntNext   = '0;
                addrNext  = '0;
              end else begin
                cntNext  = cnt + 1'b1;
                addrNext = addr + ADDR_STEP;
              end
            end
          end
          default: phaseNext = P_ISSUE;
        endcase
      end
      default: stateNext = S_IDLE;
    endcase
  end

  bram_dbg_port dPort (
    .CPU_CLK  (CPU_CLK),
    .CPU_RST_N(CPU_RST_N),
    .wrEn     (loadAcc && (state == S_LOAD_D)),
    .wrAddr   (addr),
    .wrData   (in_data),
    .rdEn     ((state == S_DUMP_D) && (phase == P_ISSUE)),
    .rdAddr   (addr),
    .capEn    ((state == S_DUMP_D) && (phase == P_CAPT)),
    .rd2      (dbg_d_rd2),
    .a2       (dbg_d_a2),
    .wd2      (dbg_d_wd2),
    .we2      (dbg_d_we2),
    .capData  (dCap)
  );

  bram_dbg_port iPort (
    .CPU_CLK  (CPU_CLK),
    .CPU_RST_N(CPU_RST_N),
    .wrEn     (loadAcc && (state == S_LOAD_I)),
    .wrAddr   (addr),
    .wrData   (in_data),
    .rdEn     ((state == S_DUMP_I) && (phase == P_ISSUE)),
    .rdAddr   (addr),
    .capEn    ((state == S_DUMP_I) && (phase == P_CAPT)),
    .rd2      (dbg_i_rd2),
    .a2       (dbg_i_a2),
    .wd2      (dbg_i_wd2),
    .we2      (dbg_i_we2),
    .capData  (iCap)
  );

endmodule

// File: tb/tb_bram_debug_sequencer.sv
// tb/tb_bram_debug_sequencer.sv - scoreboard bench for bram_debug_sequencer
module tb_bram_debug_sequencer;

  localparam int WORDS = 8;
  localparam int RUNC  = 20;
  localparam int PULSE = 5;

  logic        CPU_CLK, CPU_RST_N, start, in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        core_rst;
  logic [31:0] dbg_d_a2, dbg_d_wd2, dbg_d_rd2, dbg_i_a2, dbg_i_wd2, dbg_i_rd2;
  logic [3:0]  dbg_d_we2, dbg_i_we2;
  logic        out_valid, out_ready, out_sel, out_last, busy, done;
  logic [31:0] out_data, out_addr;

  bram_debug_sequencer #(.BRAM_WORDS(WORDS), .RUN_CYCLES(RUNC), .RST_PULSE(PULSE)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST_N(CPU_RST_N), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .core_rst(core_rst),
    .dbg_d_a2(dbg_d_a2), .dbg_d_wd2(dbg_d_wd2), .dbg_d_we2(dbg_d_we2), .dbg_d_rd2(dbg_d_rd2),
    .dbg_i_a2(dbg_i_a2), .dbg_i_wd2(dbg_i_wd2), .dbg_i_we2(dbg_i_we2), .dbg_i_rd2(dbg_i_rd2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
    .out_sel(out_sel), .out_last(out_last), .busy(busy), .done(done)
  );

  initial CPU_CLK = 1'b0;
  always #5 CPU_CLK = ~CPU_CLK;

  // Behavioural BRAMs, 1-cycle read latency; unwritten word i reads as i*3.
  bit [31:0] memD [WORDS];
  bit [31:0] memI [WORDS];
  bit [WORDS-1:0] wrD, wrI;
  always @(posedge CPU_CLK) begin
    if (dbg_d_we2 != 4'h0) begin
      memD[dbg_d_a2[4:2]] <= dbg_d_wd2;
      wrD[dbg_d_a2[4:2]]  <= 1'b1;
    end
    if (dbg_i_we2 != 4'h0) begin
      memI[dbg_i_a2[4:2]] <= dbg_i_wd2;
      wrI[dbg_i_a2[4:2]]  <= 1'b1;
    end
    dbg_d_rd2 <= wrD[dbg_d_a2[4:2]] ? memD[dbg_d_a2[4:2]] : 32'(dbg_d_a2[4:2]) * 32'd3;
    dbg_i_rd2 <= wrI[dbg_i_a2[4:2]] ? memI[dbg_i_a2[4:2]] : 32'(dbg_i_a2[4:2]) * 32'd3;
  end

  int checks = 0;
  int errors = 0;
  int beatsSeen = 0;
  int stallAt = -1;
  logic [31:0] refD [WORDS];
  logic [31:0] refI [WORDS];
  logic [63:0] expWrD[$];
  logic [63:0] expWrI[$];
  logic [65:0] expDump[$];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a write or a dump beat.
  logic        holdV = 1'b0;
  logic [31:0] holdData, holdAddr;
  always @(negedge CPU_CLK) begin : monitor
    logic [63:0] w;
    logic [65:0] d;
    if (CPU_RST_N) begin
      if (dbg_d_we2 != 4'h0) begin
        if (expWrD.size() == 0) checkVal("wr_d_unexpected_addr", dbg_d_a2, 32'hFFFF_FFFF);
        else begin
          w = expWrD.pop_front();
          checkVal("wr_d_addr", dbg_d_a2, w[63:32]);
          checkVal("wr_d_data", dbg_d_wd2, w[31:0]);
          checkVal("wr_d_we", {28'b0, dbg_d_we2}, 32'hF);
        end
      end
      if (dbg_i_we2 != 4'h0) begin
        if (expWrI.size() == 0) checkVal("wr_i_unexpected_addr", dbg_i_a2, 32'hFFFF_FFFF);
        else begin
          w = expWrI.pop_front();
          checkVal("wr_i_addr", dbg_i_a2, w[63:32]);
          checkVal("wr_i_data", dbg_i_wd2, w[31:0]);
          checkVal("wr_i_we", {28'b0, dbg_i_we2}, 32'hF);
        end
      end
      if (holdV) begin
        checkBit("hold_valid", out_valid, 1'b1);
        checkVal("hold_data", out_data, holdData);
        checkVal("hold_addr", out_addr, holdAddr);
      end
      holdV    = out_valid && !out_ready;
      holdData = out_data;
      holdAddr = out_addr;
      if (out_valid && out_ready) begin
        beatsSeen++;
        if (expDump.size() == 0) checkVal("dump_unexpected_addr", out_addr, 32'hFFFF_FFFF);
        else begin
          d = expDump.pop_front();
          checkBit("dump_sel", out_sel, d[65]);
          checkBit("dump_last", out_last, d[64]);
          checkVal("dump_addr", out_addr, d[63:32]);
          checkVal("dump_data", out_data, d[31:0]);
        end
      end
    end else begin
      holdV = 1'b0;
    end
  end

  // Dump sink: ready except for one 7-cycle stall when requested.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge CPU_CLK); #1;
      if (stallAt >= 0 && beatsSeen == stallAt) begin
        out_ready = 1'b0;
        repeat (7) @(posedge CPU_CLK);
        #1 out_ready = 1'b1;
        stallAt = -1;
      end
    end
  end

  task automatic startSeq();
    @(posedge CPU_CLK); #1 start = 1'b1;
    @(posedge CPU_CLK); #1 start = 1'b0;
  endtask

  task automatic loadImage(input int sel, input int n, input bit markLast,
                           input logic [31:0] base, input logic [31:0] step, input bit probeFull);
    int t;
    logic acc;
    for (int k = 0; k < n; k++) begin
      @(posedge CPU_CLK); #1;
      in_valid = 1'b1;
      in_data  = base + step * k;
      in_last  = markLast && (k == n - 1);
      t = 0;
      acc = 1'b0;
      while (!acc && t < 20) begin
        @(negedge CPU_CLK);
        acc = in_ready;
        t++;
      end
      checkBit("load_accept", acc, 1'b1);
      if (!acc) break;
      if (sel == 0) begin
        refD[k] = in_data;
        expWrD.push_back({32'(4 * k), in_data});
      end else begin
        refI[k] = in_data;
        expWrI.push_back({32'(4 * k), in_data});
      end
    end
    @(posedge CPU_CLK); #1;
    in_last = 1'b0;
    if (probeFull) begin
      in_data = 32'hDEAD_0009;
      @(negedge CPU_CLK);
      checkBit("in_ready_after_full", in_ready, 1'b0);
      @(posedge CPU_CLK); #1 in_valid = 1'b0;
      @(negedge CPU_CLK);
      checkBit("in_ready_load_i", in_ready, 1'b1);
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic pushDump();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < WORDS; i++)
        expDump.push_back({(s == 1), (s == 1 && i == WORDS - 1), 32'(4 * i),
                           (s == 1) ? refI[i] : refD[i]});
  endtask

  // Called right after the final InstRAM beat has been accepted.
  task automatic measureCore(input bit intrude);
    int hi, lo, k;
    hi = 0;
    lo = 0;
    k  = 0;
    while (k < 200) begin
      @(negedge CPU_CLK);
      k++;
      if (core_rst) hi++;
      else break;
    end
    if (!core_rst) begin
      lo = 1;
      while (k < 400) begin
        @(negedge CPU_CLK);
        k++;
        if (intrude && lo == 10) begin
          checkBit("in_ready_in_run", in_ready, 1'b0);
          start    = 1'b1;
          in_valid = 1'b1;
          in_data  = 32'hBAD0_BAD0;
        end else begin
          start    = 1'b0;
          in_valid = 1'b0;
        end
        if (core_rst) break;
        lo++;
      end
    end
    checkVal("core_rst_high_cycles", 32'(hi), 32'(PULSE));
    checkVal("core_rst_low_cycles", 32'(lo), 32'(RUNC));
  endtask

  task automatic waitDone();
    int k;
    k = 0;
    while (!done && k < 1000) begin
      checkBit("done_low_while_busy", done, 1'b0);
      @(negedge CPU_CLK);
      k++;
    end
    checkBit("done", done, 1'b1);
    checkBit("busy_in_done", busy, 1'b0);
    checkBit("core_rst_in_done", core_rst, 1'b1);
    checkVal("dump_all_seen", 32'(expDump.size()), 32'd0);
    checkVal("writes_all_seen", 32'(expWrD.size() + expWrI.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin : main
    int k;
    for (int i = 0; i < WORDS; i++) begin
      refD[i] = 32'(i * 3);
      refI[i] = 32'(i * 3);
    end
    CPU_RST_N = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = '0;
    repeat (3) @(posedge CPU_CLK);
    #1 CPU_RST_N = 1'b1;
    @(negedge CPU_CLK);
    checkBit("rst_core_rst", core_rst, 1'b1);
    checkBit("rst_in_ready", in_ready, 1'b0);
    checkBit("rst_out_valid", out_valid, 1'b0);
    checkBit("rst_out_last", out_last, 1'b0);
    checkBit("rst_busy", busy, 1'b0);
    checkBit("rst_done", done, 1'b0);
    checkVal("rst_out_data", out_data, 32'h0);
    checkVal("rst_out_addr", out_addr, 32'h0);
    checkBit("rst_out_sel", out_sel, 1'b0);
    checkVal("rst_d_a2", dbg_d_a2, 32'h0);
    checkVal("rst_i_wd2", dbg_i_wd2, 32'h0);

    // Sequence 1: 3-word data image, 2-word inst image, untouched words read i*3.
    startSeq();
    checkBit("busy_after_start", busy, 1'b1);
    loadImage(0, 3, 1'b1, 32'h0, 32'h1111_1111, 1'b0);
    loadImage(1, 2, 1'b1, 32'hAAAA_0000, 32'h1, 1'b0);
    pushDump();
    measureCore(1'b0);
    waitDone();

    // Sequence 2: full data image without in_last, dump backpressure.
    startSeq();
    loadImage(0, WORDS, 1'b0, 32'hD000_0000, 32'h1, 1'b1);
    loadImage(1, 1, 1'b1, 32'hBEEF_0000, 32'h1, 1'b0);
    pushDump();
    stallAt = beatsSeen + 5;
    measureCore(1'b0);
    waitDone();

    // Sequence 3: reset during RUN.
    startSeq();
    loadImage(0, 1, 1'b1, 32'h5555_0000, 32'h1, 1'b0);
    loadImage(1, 1, 1'b1, 32'h6666_0000, 32'h1, 1'b0);
    k = 0;
    while (core_rst && k < 100) begin
      @(negedge CPU_CLK);
      k++;
    end
    checkBit("run_reached", core_rst, 1'b0);
    repeat (9) @(negedge CPU_CLK);
    @(posedge CPU_CLK); #1 CPU_RST_N = 1'b0;
    @(posedge CPU_CLK); #1 CPU_RST_N = 1'b1;
    @(negedge CPU_CLK);
    checkBit("abort_core_rst", core_rst, 1'b1);
    checkBit("abort_busy", busy, 1'b0);
    checkBit("abort_done", done, 1'b0);
    checkBit("abort_out_valid", out_valid, 1'b0);
    checkBit("abort_in_ready", in_ready, 1'b0);

    // Sequence 4: fresh replay, with ignored start/in_valid during RUN.
    startSeq();
    loadImage(0, 2, 1'b1, 32'h7777_0000, 32'h10, 1'b0);
    loadImage(1, 3, 1'b1, 32'h8888_0000, 32'h100, 1'b0);
    pushDump();
    measureCore(1'b1);
    waitDone();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
